// File: rtl/div_seq.sv
// Multi-cycle 8086 DIV/IDIV sequencer: restoring division with divide-error detection.
// Define DIV_RADIX4_EN to retire two quotient bits per DIV cycle instead of one.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [15:0] y,
  input  logic        word_op,
  input  logic        signed_op,
  output logic        busy,
  output logic        done,
  output logic        div_exc,
  output logic [31:0] out
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DIV,
    FIX,
    DONE
  } state_t;

`ifdef DIV_RADIX4_EN
  localparam logic [3:0] CNT_WORD = 4'd7;
  localparam logic [3:0] CNT_BYTE = 4'd3;
`else
  localparam logic [3:0] CNT_WORD = 4'd15;
  localparam logic [3:0] CNT_BYTE = 4'd7;
`endif

  state_t      state;

  // Operands captured at acceptance; the inputs are don't-care afterwards.
  logic [31:0] x_r;
  logic [15:0] y_r;
  logic        word_r;
  logic        sgn_r;

  // Division datapath: q_r shifts dividend bits out the top and quotient bits in the bottom.
  logic [16:0] rem_r;
  logic [15:0] q_r;
  logic [15:0] d_r;
  logic        neg_q_r;
  logic        neg_r_r;
  logic        exc_r;
  logic [3:0]  cnt_r;

  // CHECK-stage magnitudes and range test
  logic        x_neg;
  logic        y_neg;
  logic [31:0] x_mag;
  logic [15:0] y_mag;
  logic [15:0] hi_mag;
  logic [15:0] lo_init;
  logic        chk_exc;

  // DIV-stage step result {rem, q}
  logic [32:0] step1;
  logic [32:0] step_next;
`ifdef DIV_RADIX4_EN
  logic [32:0] step2;
`endif

  // FIX-stage sign correction
  logic [15:0] q_mag;
  logic [15:0] r_mag;
  logic [15:0] quo_s;
  logic [15:0] rem_s;
  logic        q_ovf;
  logic [31:0] result;

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
  function automatic logic [32:0] restore_step(input logic [16:0] rem,
                                               input logic [15:0] q,
                                               input logic [15:0] d);
    logic [16:0] trial;
    trial = {rem[15:0], q[15]};
    if (rem[16] || (trial >= {1'b0, d}))
      return {trial - {1'b0, d}, q[14:0], 1'b1};
    else
      return {trial, q[14:0], 1'b0};
  endfunction

  always_comb begin
    x_neg = sgn_r & (word_r ? x_r[31] : x_r[15]);
    y_neg = sgn_r & (word_r ? y_r[15] : y_r[7]);

    if (word_r) begin
      x_mag = x_neg ? (~x_r + 32'd1) : x_r;
      y_mag = y_neg ? (~y_r + 16'd1) : y_r;
    end else begin
      x_mag = {16'd0, (x_neg ? (~x_r[15:0] + 16'd1) : x_r[15:0])};
      y_mag = {8'd0, (y_neg ? (~y_r[7:0] + 8'd1) : y_r[7:0])};
    end

    // Byte dividends sit in the top of q_r so both widths shift out of bit 15.
    hi_mag  = word_r ? x_mag[31:16] : {8'd0, x_mag[15:8]};
    lo_init = word_r ? x_mag[15:0]  : {x_mag[7:0], 8'd0};

    // Zero divisor is covered too: any high half is >= 0.
    chk_exc = (hi_mag >= y_mag);
  end

  always_comb begin
    step1     = restore_step(rem_r, q_r, d_r);
`ifdef DIV_RADIX4_EN
    step2     = restore_step(step1[32:16], step1[15:0], d_r);
    step_next = step2;
`else
    step_next = step1;
`endif
  end

  always_comb begin
    q_mag  = word_r ? q_r : {8'd0, q_r[7:0]};
    r_mag  = word_r ? rem_r[15:0] : {8'd0, rem_r[7:0]};
    quo_s  = neg_q_r ? (~q_mag + 16'd1) : q_mag;
    rem_s  = neg_r_r ? (~r_mag + 16'd1) : r_mag;
    // 8086 rejects any signed quotient magnitude >= 2^(N-1), including the exact negative limit.
    q_ovf  = sgn_r & (word_r ? q_r[15] : q_r[7]);
    result = word_r ? {rem_s, quo_s} : {16'd0, rem_s[7:0], quo_s[7:0]};
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values; the reset branch is synchronous because rst is sampled on clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      div_exc <= 1'b0;
      out     <= '0;
      x_r     <= '0;
      y_r     <= '0;
      word_r  <= 1'b0;
      sgn_r   <= 1'b0;
      rem_r   <= '0;
      q_r     <= '0;
      d_r     <= '0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      exc_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          div_exc <= 1'b0;
          if (start) begin
            x_r    <= x;
            y_r    <= y;
            word_r <= word_op;
            sgn_r  <= signed_op;
            busy   <= 1'b1;
            state  <= CHECK;
          end
        end

        CHECK: begin
          rem_r   <= {1'b0, hi_mag};
          q_r     <= lo_init;
          d_r     <= y_mag;
          neg_q_r <= x_neg ^ y_neg;
          neg_r_r <= x_neg;
          exc_r   <= chk_exc;
          cnt_r   <= word_r ? CNT_WORD : CNT_BYTE;
          state   <= DIV;
        end

        DIV: begin
          if (exc_r) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            div_exc <= 1'b1;
            state   <= DONE;
          end else begin
            rem_r <= step_next[32:16];
            q_r   <= step_next[15:0];
            if (cnt_r == 4'd0)
              state <= FIX;
            else
              cnt_r <= cnt_r - 4'd1;
          end
        end

        FIX: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          div_exc <= q_ovf;
          if (!q_ovf)
            out <= result;
          state   <= DONE;
        end

        DONE: begin
          done    <= 1'b0;
          div_exc <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          div_exc <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: results, exception paths, latencies, busy/start handling and reset abort.
module tb_div_seq;

`ifdef DIV_RADIX4_EN
  localparam int W_LAT = 10;
  localparam int B_LAT = 6;
`else
  localparam int W_LAT = 18;
  localparam int B_LAT = 10;
`endif
  localparam int E_LAT = 2;
  localparam int MAX_EDGES = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] x;
  logic [15:0] y;
  logic        word_op;
  logic        signed_op;
  logic        busy;
  logic        done;
  logic        div_exc;
  logic [31:0] out;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] last_out   = 32'h0;

  div_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x         (x),
    .y         (y),
    .word_op   (word_op),
    .signed_op (signed_op),
    .busy      (busy),
    .done      (done),
    .div_exc   (div_exc),
    .out       (out)
  );

  always #5 clk = ~clk;

  // Runs one operation; poke >= 0 drives a spurious start after that edge count.
  task automatic do_op(input string name, input logic [31:0] xi, input logic [15:0] yi,
                       input logic w, input logic s, input int lat, input logic exc,
                       input logic [31:0] exp_out, input int poke);
    int          edges;
    logic        seen;
    logic [31:0] req_out;
    req_out = exc ? last_out : exp_out;

    @(negedge clk);
    x = xi; y = yi; word_op = w; signed_op = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; x = 32'hDEAD_BEEF; y = 16'hBEEF; word_op = ~w; signed_op = ~s;

    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL %s busy_after_accept: got %b expected 1", name, busy);
    end

    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < MAX_EDGES) begin
      @(posedge clk); #1;
      edges++;
      start = 1'b0;
      if (done === 1'b1) seen = 1'b1;
      if (edges == poke) begin
        start = 1'b1; x = 32'h0000_0064; y = 16'h0007; word_op = 1'b0; signed_op = 1'b0;
      end
    end

    compared++;
    if (!seen || edges != lat) begin
      mismatched++;
      $display("FAIL %s latency: got %0d edges (done seen=%b) expected %0d", name, edges, seen, lat);
    end

    if (seen) begin
      compared++;
      if (div_exc !== exc) begin
        mismatched++;
        $display("FAIL %s div_exc: got %b expected %b", name, div_exc, exc);
      end
      compared++;
      if (out !== req_out) begin
        mismatched++;
        $display("FAIL %s out: got %h expected %h", name, out, req_out);
      end
      compared++;
      if (busy !== 1'b0) begin
        mismatched++;
        $display("FAIL %s busy_in_done: got %b expected 0", name, busy);
      end
    end

    @(posedge clk); #1;
    start = 1'b0;
    compared++;
    if ({done, div_exc, busy} !== 3'b000) begin
      mismatched++;
      $display("FAIL %s after_done {done,exc,busy}: got %b expected 000", name, {done, div_exc, busy});
    end

    if (!exc) last_out = exp_out;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; x = '0; y = '0; word_op = 1'b0; signed_op = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset busy: got %b expected 0", busy); end
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("FAIL reset done: got %b expected 0", done); end
    compared++;
    if (div_exc !== 1'b0) begin mismatched++; $display("FAIL reset div_exc: got %b expected 0", div_exc); end
    compared++;
    if (out !== 32'h0) begin mismatched++; $display("FAIL reset out: got %h expected 0", out); end
    @(negedge clk);
    rst = 1'b0;
    last_out = 32'h0;
  endtask

  task automatic test_unsigned();
    do_op("div_w_65536_2",   32'h0001_0000, 16'h0002, 1'b1, 1'b0, W_LAT, 1'b0, 32'h0000_8000, -1);
    do_op("div_b_100_7",     32'h0000_0064, 16'h0007, 1'b0, 1'b0, B_LAT, 1'b0, 32'h0000_020E, -1);
    do_op("div_w_123456",    32'h0012_3456, 16'h1234, 1'b1, 1'b0, W_LAT, 1'b0, 32'h0056_0100, -1);
    do_op("div_b_max",       32'h0000_FEFF, 16'h00FF, 1'b0, 1'b0, B_LAT, 1'b0, 32'h0000_FEFF, -1);
  endtask

  task automatic test_signed();
    do_op("idiv_w_m100_7",   32'hFFFF_FF9C, 16'h0007, 1'b1, 1'b1, W_LAT, 1'b0, 32'hFFFE_FFF2, -1);
    do_op("idiv_b_m100_m7",  32'h0000_FF9C, 16'h00F9, 1'b0, 1'b1, B_LAT, 1'b0, 32'h0000_FE0E, -1);
    do_op("idiv_w_100_m7",   32'h0000_0064, 16'hFFF9, 1'b1, 1'b1, W_LAT, 1'b0, 32'h0002_FFF2, -1);
    do_op("idiv_w_m32767_1", 32'hFFFF_8001, 16'h0001, 1'b1, 1'b1, W_LAT, 1'b0, 32'h0000_8001, -1);
  endtask

  task automatic test_exceptions();
    do_op("exc_w_div0",      32'h0000_1234, 16'h0000, 1'b1, 1'b0, E_LAT, 1'b1, 32'h0, -1);
    do_op("exc_w_ovf",       32'h0002_0000, 16'h0002, 1'b1, 1'b0, E_LAT, 1'b1, 32'h0, -1);
    do_op("exc_b_ovf",       32'h0000_0200, 16'h0002, 1'b0, 1'b0, E_LAT, 1'b1, 32'h0, -1);
    do_op("exc_iw_ovf_hi",   32'hFFFE_0000, 16'h0002, 1'b1, 1'b1, E_LAT, 1'b1, 32'h0, -1);
    do_op("exc_iw_8000_1",   32'h0000_8000, 16'h0001, 1'b1, 1'b1, W_LAT, 1'b1, 32'h0, -1);
    do_op("exc_ib_m128_1",   32'h0000_FF80, 16'h0001, 1'b0, 1'b1, B_LAT, 1'b1, 32'h0, -1);
    do_op("idiv_w_8000_2",   32'h0000_8000, 16'h0002, 1'b1, 1'b1, W_LAT, 1'b0, 32'h0000_4000, -1);
  endtask

  task automatic test_busy_ignore();
    do_op("start_while_busy", 32'h0001_0000, 16'h0002, 1'b1, 1'b0, W_LAT, 1'b0, 32'h0000_8000, 3);
    do_op("start_in_done",    32'h0000_0064, 16'h0007, 1'b0, 1'b0, B_LAT, 1'b0, 32'h0000_020E, B_LAT);
  endtask

  task automatic test_reset_abort();
    int done_seen;
    @(negedge clk);
    x = 32'h0001_0000; y = 16'h0002; word_op = 1'b1; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    compared++;
    if ({busy, done, out} !== 34'h0) begin
      mismatched++;
      $display("FAIL abort_state {busy,done,out}: got %b %b %h expected 0 0 00000000", busy, done, out);
    end
    @(negedge clk);
    rst = 1'b0;
    last_out = 32'h0;
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) done_seen++;
    end
    compared++;
    if (done_seen != 0) begin
      mismatched++;
      $display("FAIL abort_no_done: got %0d done cycles expected 0", done_seen);
    end
    do_op("restart_after_abort", 32'h0001_0000, 16'h0002, 1'b1, 1'b0, W_LAT, 1'b0, 32'h0000_8000, -1);
  endtask

  task automatic test_back_to_back();
    do_op("b2b_w_max_quo", 32'hFFFE_FFFF, 16'hFFFF, 1'b1, 1'b0, W_LAT, 1'b0, 32'hFFFE_FFFF, -1);
    do_op("b2b_ib_127_1",  32'h0000_007F, 16'h0001, 1'b0, 1'b1, B_LAT, 1'b0, 32'h0000_007F, -1);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_exceptions();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
